// File: rtl/io_uart_pkg.sv
// Shared types and bit positions for the memory-mapped UART transmitter.
package io_uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned ST_FULL  = 7;
    localparam int unsigned ST_EMPTY = 6;
    localparam int unsigned ST_BUSY  = 5;
    localparam int unsigned ST_OVF   = 4;

    localparam int unsigned CTL_WR    = 0;
    localparam int unsigned CTL_FLUSH = 1;
    localparam int unsigned CTL_CLR   = 2;

endpackage

// File: rtl/io_uart_tx_if.sv
// I/O port bundle between the data memory's I/O ports and the UART transmitter.
interface io_uart_tx_if;
    logic [7:0] IOD;
    logic [7:0] IOE;
    logic       TXD;
    logic [7:0] STATUS;

    modport master (output IOD, output IOE, input TXD, input STATUS);
    modport slave  (input IOD, input IOE, output TXD, output STATUS);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
module uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= din;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: edge-triggered control strobes, byte FIFO,
// frame FSM with shifter, and a registered status byte for software polling.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    io_uart_tx_if.slave   bus
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    tx_state_e      state;
    tx_state_e      state_n;
    logic [BW-1:0]  baud;
    logic [BW-1:0]  baud_n;
    logic [2:0]     bit_idx;
    logic [2:0]     bit_n;
    logic [7:0]     shifter;
    logic [7:0]     shift_n;
    logic           txd_q;
    logic           txd_n;
    logic           baud_last;

    logic [2:0]     ctl;
    logic [2:0]     ioe_q;
    logic           wr_edge;
    logic           flush_edge;
    logic           clr_edge;
    logic           push;
    logic           pop;
    logic           ovf;
    logic           ovf_set;
    logic           unused_ioe;

    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     status_q;
    logic [7:0]     status_n;

    assign ctl        = bus.IOE[2:0];
    assign unused_ioe = &{1'b0, bus.IOE[7:3]};
    assign wr_edge    = ctl[CTL_WR]    & ~ioe_q[CTL_WR];
    assign flush_edge = ctl[CTL_FLUSH] & ~ioe_q[CTL_FLUSH];
    assign clr_edge   = ctl[CTL_CLR]   & ~ioe_q[CTL_CLR];

    // Flush beats a coincident write: the byte is discarded without flagging overflow.
    assign push    = wr_edge & ~flush_edge & (~fifo_full | pop);
    assign ovf_set = wr_edge & ~flush_edge & fifo_full & ~pop;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (push),
        .pop   (pop),
        .flush (flush_edge),
        .din   (bus.IOD),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_n = state;
        baud_n  = baud + 1'b1;
        bit_n   = bit_idx;
        shift_n = shifter;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shifter[7:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Line level is computed from the next state so the TXD flop changes with the FSM.
        unique case (state_n)
            S_START: txd_n = 1'b0;
            S_DATA:  txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    always_comb begin
        status_n           = '0;
        status_n[ST_FULL]  = fifo_full;
        status_n[ST_EMPTY] = fifo_empty;
        status_n[ST_BUSY]  = (state != S_IDLE);
        status_n[ST_OVF]   = ovf;
        status_n[3:0]      = 4'(fifo_count);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            txd_q    <= 1'b1;
            ioe_q    <= '0;
            ovf      <= 1'b0;
            status_q <= 8'h40;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_n;
            shifter  <= shift_n;
            txd_q    <= txd_n;
            ioe_q    <= ctl;
            status_q <= status_n;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_edge) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.TXD    = txd_q;
    assign bus.STATUS = status_q;

endmodule
